// File: rtl/stack_seq.sv
`default_nettype none
// ============================================================================
// Module   : stack_seq
// Purpose  : Stack-operation sequencer sitting upstream of the stack pointer.
//            Accepts one PUSH / POP / PEEK / DROP command at a time. It checks
//            for overflow and underflow, then runs the memory access and
//            drives the pointer update pulses.
// Ports    : clk, ir_reset           - clock, synchronous active-high reset
//            op_valid/op_ready       - command handshake (ready == IDLE)
//            op_code/op_arg/op_data  - command, DROP count-1, PUSH data
//            sp_addr                 - current stack pointer (bits [11:0] used)
//            stack_load/sp_add/ram_arg - pointer decrement / add controls
//            mem_*                   - data memory request/ack interface
//            result/result_valid     - POP/PEEK read data
//            err/err_code            - rejection pulse, 01 overflow 10 underflow
// Revision : 1.0 - initial release
// ============================================================================
module stack_seq (
  input  logic        clk,
  input  logic        ir_reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  op_code,
  input  logic [9:0]  op_arg,
  input  logic [15:0] op_data,
  input  logic [15:0] sp_addr,
  output logic        stack_load,
  output logic        sp_add,
  output logic [9:0]  ram_arg,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] result,
  output logic        result_valid,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_DEC   = 3'd2;
  localparam logic [2:0] S_INC   = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;
  localparam logic [2:0] S_ADJ   = 3'd5;

  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_PEEK = 3'b011;
  localparam logic [2:0] OP_DROP = 3'b100;

  localparam logic [1:0] E_OVF = 2'b01;
  localparam logic [1:0] E_UDF = 2'b10;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [2:0]  r_op;
  logic [9:0]  r_arg;
  logic [15:0] r_data;
  logic [15:0] r_result;
  logic        r_result_valid;
  logic        r_err;
  logic [1:0]  r_err_code;

  logic        w_accept;
  logic        w_reject;
  logic [1:0]  w_rej_code;
  logic [11:0] w_p;
  logic [11:0] w_p_inc;
  logic [12:0] w_drop_sum;
  logic        w_empty;
  logic        w_unused_sp_hi;

  assign w_p            = sp_addr[11:0];
  assign w_p_inc        = w_p + 12'd1;
  assign w_empty        = (w_p == 12'hFFF);
  // 13-bit sum so a DROP that would wrap past the empty mark is caught
  assign w_drop_sum     = {1'b0, w_p} + {3'b000, op_arg} + 13'd1;
  assign w_unused_sp_hi = &{1'b0, sp_addr[15:12]};
  assign w_accept       = op_valid && (r_state == S_IDLE);

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (ir_reset) begin
      r_state        <= S_IDLE;
      r_op           <= 3'd0;
      r_arg          <= 10'd0;
      r_data         <= 16'd0;
      r_result       <= 16'd0;
      r_result_valid <= 1'b0;
      r_err          <= 1'b0;
      r_err_code     <= 2'b00;
    end else begin
      r_state        <= w_next;
      r_result_valid <= (r_state == S_READ) && mem_ack;
      r_err          <= w_reject;
      if (w_accept) begin
        r_op   <= op_code;
        r_arg  <= op_arg;
        r_data <= op_data;
      end
      if ((r_state == S_READ) && mem_ack) begin
        r_result <= mem_rdata;
      end
      if (w_reject) begin
        r_err_code <= w_rej_code;
      end
    end
  end

  // Next-state logic, including the acceptance-time bounds check
  always_comb begin
    w_next     = r_state;
    w_reject   = 1'b0;
    w_rej_code = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (op_code)
            OP_PUSH: begin
              if (w_p == 12'h000) begin
                w_reject   = 1'b1;
                w_rej_code = E_OVF;
              end else begin
                w_next = S_WRITE;
              end
            end
            OP_POP: begin
              if (w_empty) begin
                w_reject   = 1'b1;
                w_rej_code = E_UDF;
              end else begin
                w_next = S_INC;
              end
            end
            OP_PEEK: begin
              if (w_empty) begin
                w_reject   = 1'b1;
                w_rej_code = E_UDF;
              end else begin
                w_next = S_READ;
              end
            end
            OP_DROP: begin
              if (w_drop_sum > 13'h0FFF) begin
                w_reject   = 1'b1;
                w_rej_code = E_UDF;
              end else begin
                w_next = S_ADJ;
              end
            end
            default: w_next = S_IDLE;
          endcase
        end
      end
      S_WRITE: if (mem_ack) w_next = S_DEC;
      S_DEC:   w_next = S_IDLE;
      S_INC:   w_next = S_READ;
      S_READ:  if (mem_ack) w_next = S_IDLE;
      S_ADJ:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Per-state control outputs; addresses track the live pointer, which does
  // not move while a request is outstanding, so requests stay stable.
  always_comb begin
    stack_load = 1'b0;
    sp_add     = 1'b0;
    ram_arg    = 10'd0;
    mem_addr   = 16'd0;
    mem_wdata  = 16'd0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    case (r_state)
      S_WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = {4'b0000, w_p};
        mem_wdata = r_data;
      end
      S_DEC: stack_load = 1'b1;
      S_INC: sp_add = 1'b1;
      S_READ: begin
        mem_re   = 1'b1;
        // POP has already moved the pointer onto the top entry; PEEK has not
        mem_addr = (r_op == OP_POP) ? {4'b0000, w_p} : {4'b0000, w_p_inc};
      end
      S_ADJ: begin
        sp_add  = 1'b1;
        ram_arg = r_arg;
      end
      default: ;
    endcase
  end

  assign op_ready     = (r_state == S_IDLE);
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign err          = r_err;
  assign err_code     = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_stack_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_seq
// Purpose  : Scoreboard bench for stack_seq with a stack-pointer model and a
//            variable-latency data memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stack_seq;

  localparam int K_WR  = 0;
  localparam int K_RD  = 1;
  localparam int K_RES = 2;
  localparam int K_ERR = 3;

  typedef struct {
    int          kind;
    logic [15:0] a;
    logic [15:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        ir_reset, op_valid, op_ready;
  logic [2:0]  op_code;
  logic [9:0]  op_arg;
  logic [15:0] op_data, sp_addr;
  logic        stack_load, sp_add;
  logic [9:0]  ram_arg;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re, mem_ack;
  logic [15:0] result;
  logic        result_valid, err;
  logic [1:0]  err_code;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

  // Memory model state
  logic [15:0] mem [0:4095];
  int          delay = 0;
  int          wcnt = 0;
  logic        force_ack = 1'b0;

  // Stack-pointer model state
  logic [15:0] r_sp;
  logic        sp_set = 1'b0;
  logic [15:0] sp_set_val = 16'h0;

  // Monitor tallies
  int          n_sl = 0, n_sa = 0, n_we = 0, n_re = 0;
  logic [9:0]  last_ram_arg = 10'd0;

  always #5 clk = ~clk;

  stack_seq dut (
    .clk(clk), .ir_reset(ir_reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_arg(op_arg), .op_data(op_data), .sp_addr(sp_addr),
    .stack_load(stack_load), .sp_add(sp_add), .ram_arg(ram_arg),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .result(result),
    .result_valid(result_valid), .err(err), .err_code(err_code)
  );

  assign sp_addr   = r_sp;
  assign mem_ack   = force_ack | ((mem_we | mem_re) && (wcnt >= delay));
  assign mem_rdata = mem[mem_addr[11:0]];

  always @(posedge clk) begin
    if (ir_reset)        r_sp <= 16'h0FFF;
    else if (sp_set)     r_sp <= sp_set_val;
    else if (stack_load) r_sp <= {4'h0, r_sp[11:0] - 12'd1};
    else if (sp_add)     r_sp <= {4'h0, r_sp[11:0] + {2'b00, ram_arg} + 12'd1};
  end

  always @(posedge clk) begin
    if (!(mem_we | mem_re) || mem_ack) wcnt <= 0;
    else                               wcnt <= wcnt + 1;
    if (mem_we && mem_ack) mem[mem_addr[11:0]] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    e.kind = kind; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input string name, input int kind, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: unexpected event a=%h d=%h, none expected", name, a, d);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_kind"}, kind, e.kind);
      chk({name, "_addr"}, {16'h0, a}, {16'h0, e.a});
      chk({name, "_data"}, {16'h0, d}, {16'h0, e.d});
    end
  endtask

  // Monitor: samples on the falling edge, decoupled from stimulus
  logic        prev_we_wait = 1'b0;
  logic [15:0] prev_addr = 16'h0, prev_wdata = 16'h0;
  initial begin
    forever begin
      @(negedge clk);
      if (mem_we && mem_re) begin
        checks++; failures++;
        $display("FAIL we_re_excl: got we=1 re=1 expected not both");
      end
      if (stack_load && sp_add) begin
        checks++; failures++;
        $display("FAIL sl_sa_excl: got both expected at most one");
      end
      if (stack_load) n_sl++;
      if (sp_add) begin n_sa++; last_ram_arg = ram_arg; end
      if (mem_we) n_we++;
      if (mem_re) n_re++;
      if (mem_we && prev_we_wait) begin
        chk("we_hold_addr", {16'h0, mem_addr}, {16'h0, prev_addr});
        chk("we_hold_data", {16'h0, mem_wdata}, {16'h0, prev_wdata});
      end
      prev_we_wait = mem_we && !mem_ack;
      prev_addr    = mem_addr;
      prev_wdata   = mem_wdata;
      if (mem_we && mem_ack) sb_pop("write", K_WR, mem_addr, mem_wdata);
      if (mem_re && mem_ack) sb_pop("read", K_RD, mem_addr, 16'h0);
      if (result_valid)      sb_pop("result", K_RES, 16'h0, result);
      if (err)               sb_pop("err", K_ERR, 16'h0, {14'h0, err_code});
    end
  end

  task automatic issue(input logic [2:0] code, input logic [9:0] arg, input logic [15:0] data);
    int n = 0;
    while (!op_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!op_ready) chk("issue_timeout_ready", 0, 1);
    op_valid = 1'b1; op_code = code; op_arg = arg; op_data = data;
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 3'd0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!op_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!op_ready) chk("idle_timeout_ready", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic set_sp(input logic [15:0] v);
    sp_set = 1'b1; sp_set_val = v;
    @(posedge clk); #1;
    sp_set = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_sa, s_re, s_we, s_sl;
    ir_reset = 1'b1; op_valid = 1'b0; op_code = 3'd0; op_arg = 10'd0; op_data = 16'd0;
    repeat (3) @(posedge clk);
    #1 ir_reset = 1'b0;

    // Reset state
    chk("rst_ready", {31'h0, op_ready}, 1);
    chk("rst_result", {16'h0, result}, 0);
    chk("rst_err_code", {30'h0, err_code}, 0);
    chk("rst_mem_we_re", {30'h0, mem_we, mem_re}, 0);
    chk("rst_ram_arg", {22'h0, ram_arg}, 0);
    chk("rst_mem_addr", {16'h0, mem_addr}, 0);

    // Underflow right after reset
    s_sa = n_sa; s_re = n_re;
    expect_ev(K_ERR, 16'h0, 16'h0002);
    issue(3'b010, 10'd0, 16'h0);
    wait_idle();
    expect_ev(K_ERR, 16'h0, 16'h0002);
    issue(3'b011, 10'd0, 16'h0);
    wait_idle();
    chk("udf_no_sp_add", n_sa - s_sa, 0);
    chk("udf_no_mem_re", n_re - s_re, 0);
    chk("udf_sp_kept", {16'h0, sp_addr}, 32'h0FFF);

    // PUSH x2 with zero-wait memory, latency check on the first
    expect_ev(K_WR, 16'h0FFF, 16'h1234);
    issue(3'b001, 10'd0, 16'h1234);
    chk("push_busy_c1", {31'h0, op_ready}, 0);
    @(posedge clk); #1;
    chk("push_busy_c2", {31'h0, op_ready}, 0);
    @(posedge clk); #1;
    chk("push_ready_c3", {31'h0, op_ready}, 1);
    expect_ev(K_WR, 16'h0FFE, 16'hBEEF);
    issue(3'b001, 10'd0, 16'hBEEF);
    wait_idle();
    chk("push2_sp", {16'h0, sp_addr}, 32'h0FFD);

    // POP x2
    expect_ev(K_RD, 16'h0FFE, 16'h0);
    expect_ev(K_RES, 16'h0, 16'hBEEF);
    issue(3'b010, 10'd0, 16'h0);
    wait_idle();
    expect_ev(K_RD, 16'h0FFF, 16'h0);
    expect_ev(K_RES, 16'h0, 16'h1234);
    issue(3'b010, 10'd0, 16'h0);
    wait_idle();
    chk("pop2_sp", {16'h0, sp_addr}, 32'h0FFF);
    chk("pop2_result_hold", {16'h0, result}, 32'h1234);

    // Overflow at a full stack
    set_sp(16'h0000);
    s_we = n_we; s_sl = n_sl;
    expect_ev(K_ERR, 16'h0, 16'h0001);
    issue(3'b001, 10'd0, 16'h5555);
    wait_idle();
    chk("ovf_no_we", n_we - s_we, 0);
    chk("ovf_no_stack_load", n_sl - s_sl, 0);
    chk("ovf_err_code_hold", {30'h0, err_code}, 1);

    // DROP boundary: 15 entries fit, 16 do not
    set_sp(16'h0FF0);
    s_sa = n_sa;
    issue(3'b100, 10'd14, 16'h0);
    wait_idle();
    chk("drop14_pulses", n_sa - s_sa, 1);
    chk("drop14_ram_arg", {22'h0, last_ram_arg}, 14);
    chk("drop14_sp", {16'h0, sp_addr}, 32'h0FFF);
    set_sp(16'h0FF0);
    s_sa = n_sa;
    expect_ev(K_ERR, 16'h0, 16'h0002);
    issue(3'b100, 10'd15, 16'h0);
    wait_idle();
    chk("drop15_no_pulse", n_sa - s_sa, 0);
    chk("drop15_sp", {16'h0, sp_addr}, 32'h0FF0);

    // NOP code does nothing
    s_sa = n_sa; s_we = n_we;
    issue(3'b111, 10'd0, 16'h0);
    chk("nop_ready", {31'h0, op_ready}, 1);
    wait_idle();
    chk("nop_no_activity", (n_sa - s_sa) + (n_we - s_we), 0);

    // Stalled PUSH (3 wait cycles), then PEEK
    ir_reset = 1'b1; @(posedge clk); #1; ir_reset = 1'b0;
    delay = 3;
    s_we = n_we; s_sl = n_sl;
    expect_ev(K_WR, 16'h0FFF, 16'hCAFE);
    issue(3'b001, 10'd0, 16'hCAFE);
    wait_idle();
    chk("slow_push_we_cycles", n_we - s_we, 4);
    chk("slow_push_one_dec", n_sl - s_sl, 1);
    chk("slow_push_sp", {16'h0, sp_addr}, 32'h0FFE);
    delay = 0;
    expect_ev(K_RD, 16'h0FFF, 16'h0);
    expect_ev(K_RES, 16'h0, 16'hCAFE);
    issue(3'b011, 10'd0, 16'h0);
    wait_idle();
    chk("peek_sp_kept", {16'h0, sp_addr}, 32'h0FFE);

    // Reset during a stalled READ, then a stray ack
    delay = 10;
    issue(3'b011, 10'd0, 16'h0);
    chk("stall_re_c1", {31'h0, mem_re}, 1);
    @(posedge clk); #1;
    ir_reset = 1'b1;
    @(posedge clk); #1;
    ir_reset = 1'b0;
    chk("rstrd_mem_re", {31'h0, mem_re}, 0);
    chk("rstrd_ready", {31'h0, op_ready}, 1);
    chk("rstrd_result", {16'h0, result}, 0);
    force_ack = 1'b1;
    @(posedge clk); #1;
    force_ack = 1'b0;
    chk("late_ack_no_valid", {31'h0, result_valid}, 0);
    chk("late_ack_result", {16'h0, result}, 0);
    chk("late_ack_ready", {31'h0, op_ready}, 1);
    delay = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
